// File: rtl/board_pos_writer.sv
// board_pos_writer: write-side master for the display position table.
// Buffers slot updates in a small FIFO and drains them onto BRAM port A, one
// registered write per cycle. It also runs a bulk clear that zeroes every slot.
//
// state | meaning
// IDLE  | drain the FIFO; start a bulk clear once the FIFO is empty
// CLEAR | zero slots 0..NUM_POS-1, one write per cycle
module board_pos_writer #(
  parameter int                    WIDTH      = 16,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h100,
  parameter int                    NUM_POS    = 30,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk50MHz,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_index,
  input  logic [WIDTH-1:0]      req_data,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  err_index,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [WIDTH-1:0]      data_a,
  output logic                  we_a,
  output logic [7:0]            write_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(NUM_POS + 1);
  localparam logic [5:0]            NUM_POS_W = 6'(NUM_POS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BASE_ADDR + ADDR_WIDTH'(NUM_POS - 1));
  localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(NUM_POS - 1);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [4:0]       idx;
    logic [WIDTH-1:0] data;
  } entry_t;

  state_t                state_q, state_d;
  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  clear_pending_q, clear_pending_d;
  logic [CNT_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  err_q, err_d;
  logic [7:0]            count_q, count_d;

  logic   fifo_empty, fifo_full, accept, idx_ok, push, pop;
  entry_t head;

  // FIFO status and the request handshake
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    req_ready  = !fifo_full && (state_q == IDLE) && !clear_pending_q;
    accept     = req_valid && req_ready;
    idx_ok     = ({1'b0, req_index} < NUM_POS_W);
    push       = accept && idx_ok;
    pop        = (state_q == IDLE) && !fifo_empty;
    head       = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  // Next-state, write-port and bookkeeping logic
  always_comb begin
    state_d         = state_q;
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    clear_pending_d = clear_pending_q;
    clr_cnt_d       = clr_cnt_q;
    we_d            = 1'b0;
    addr_d          = addr_q;
    data_d          = data_q;
    err_d           = accept && !idx_ok;

    case (state_q)
      IDLE: begin
        if (pop) begin
          we_d     = 1'b1;
          addr_d   = BASE_ADDR + ADDR_WIDTH'(head.idx);
          data_d   = head.data;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (clear_pending_q) begin
          state_d         = CLEAR;
          clear_pending_d = 1'b0;
          clr_cnt_d       = CNT_LOAD;
        end
      end
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = LAST_ADDR - ADDR_WIDTH'(clr_cnt_q);
        data_d = '0;
        if (clr_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new clear request wins over the pending flag being consumed this cycle.
    if (clear_req && (state_q != CLEAR)) begin
      clear_pending_d = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = '{idx: req_index, data: req_data};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    count_d = count_q + {7'b0, we_d};
  end

  // Control and output registers
  always_ff @(posedge clk50MHz or posedge clr) begin
    if (clr) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      clear_pending_q <= 1'b0;
      clr_cnt_q       <= '0;
      we_q            <= 1'b0;
      addr_q          <= BASE_ADDR;
      data_q          <= '0;
      err_q           <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      clear_pending_q <= clear_pending_d;
      clr_cnt_q       <= clr_cnt_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      err_q           <= err_d;
      count_q         <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so it needs no reset
  always_ff @(posedge clk50MHz) begin
    mem_q <= mem_d;
  end

  // Output assignments
  always_comb begin
    we_a        = we_q;
    addr_a      = addr_q;
    data_a      = data_q;
    err_index   = err_q;
    write_count = count_q;
    busy        = (state_q != IDLE) || !fifo_empty || clear_pending_q || we_q;
  end

endmodule

// File: tb/tb_board_pos_writer.sv
// Testbench for board_pos_writer: table vectors, directed corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_board_pos_writer;
  localparam int         NUM_POS = 30;
  localparam logic [9:0] BASE    = 10'h100;

  logic        clk50MHz = 1'b0;
  logic        clr = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_index = '0;
  logic [15:0] req_data = '0;
  logic        clear_req = 1'b0;
  logic        busy, err_index, we_a;
  logic [9:0]  addr_a;
  logic [15:0] data_a;
  logic [7:0]  write_count;

  board_pos_writer dut (
    .clk50MHz(clk50MHz), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_data(req_data), .clear_req(clear_req), .busy(busy),
    .err_index(err_index), .addr_a(addr_a), .data_a(data_a), .we_a(we_a),
    .write_count(write_count)
  );

  always #10 clk50MHz = ~clk50MHz;

  int tests = 0;
  int fails = 0;

  // Reference model: pending writes as a queue, clear progress as a count of slots left
  typedef struct {logic [9:0] a; logic [15:0] d;} wr_t;
  wr_t        mq[$];
  bit         m_cp;
  int         m_left;
  bit         m_we, m_err;
  logic [9:0] m_addr;
  logic [15:0] m_data;
  logic [7:0] m_cnt;

  typedef struct {
    bit         valid;
    logic [4:0] idx;
    logic [15:0] data;
    bit         clr_req;
    bit         e_we;
    logic [9:0] e_addr;
    logic [15:0] e_data;
    bit         e_err;
    logic [7:0] e_cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (mq.size() < 4) && (m_left == 0) && !m_cp;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cp = 0; m_left = 0; m_we = 0; m_err = 0;
    m_addr = BASE; m_data = '0; m_cnt = '0;
  endtask

  task automatic model_edge();
    bit  acc, in_clr, wr;
    wr_t w;
    acc    = req_valid && m_ready();
    in_clr = (m_left > 0);
    wr     = 0;
    w      = '{a: m_addr, d: m_data};
    if (in_clr) begin
      wr = 1; w.a = BASE + 10'(NUM_POS - m_left); w.d = '0; m_left--;
    end else if (mq.size() > 0) begin
      wr = 1; w = mq.pop_front();
    end else if (m_cp) begin
      m_left = NUM_POS; m_cp = 0;
    end
    if (clear_req && !in_clr) m_cp = 1;
    if (acc && req_index < NUM_POS) mq.push_back('{a: BASE + 10'(req_index), d: req_data});
    m_err = acc && (req_index >= NUM_POS);
    m_we  = wr;
    if (wr) begin m_addr = w.a; m_data = w.d; m_cnt = m_cnt + 8'd1; end
  endtask

  task automatic check_outs();
    chk("we_a", we_a, m_we);
    chk("addr_a", addr_a, m_addr);
    chk("data_a", data_a, m_data);
    chk("err_index", err_index, m_err);
    chk("write_count", write_count, m_cnt);
    chk("busy", busy, (m_left > 0) || (mq.size() > 0) || m_cp || m_we);
  endtask

  // One clock: inputs already driven; check ready, clock, check outputs, go to negedge
  task automatic step();
    chk("req_ready", req_ready, m_ready());
    @(posedge clk50MHz);
    model_edge();
    #1;
    check_outs();
    @(negedge clk50MHz);
  endtask

  task automatic drive(input bit v, input logic [4:0] i, input logic [15:0] d, input bit c);
    req_valid = v; req_index = i; req_data = d; clear_req = c;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    #3 clr = 1'b1;
    #2;
    model_reset();
    chk("rst_we", we_a, 1'b0);
    chk("rst_addr", addr_a, BASE);
    chk("rst_count", write_count, 8'd0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk50MHz);
    clr = 1'b0;
  endtask

  vec_t vecs[6];
  logic [7:0] c0;

  initial begin
    // single write, out-of-range drop, follow-up write
    vecs[0] = '{1, 5'd5,  16'h0A3C, 0, 0, 10'h100, 16'h0000, 0, 8'd0};
    vecs[1] = '{0, 5'd0,  16'h0000, 0, 1, 10'h105, 16'h0A3C, 0, 8'd1};
    vecs[2] = '{1, 5'd30, 16'hFFFF, 0, 0, 10'h105, 16'h0A3C, 1, 8'd1};
    vecs[3] = '{1, 5'd7,  16'h1111, 0, 0, 10'h105, 16'h0A3C, 0, 8'd1};
    vecs[4] = '{0, 5'd0,  16'h0000, 0, 1, 10'h107, 16'h1111, 0, 8'd2};
    vecs[5] = '{0, 5'd0,  16'h0000, 0, 0, 10'h107, 16'h1111, 0, 8'd2};

    model_reset();
    @(negedge clk50MHz);
    @(negedge clk50MHz);
    clr = 1'b0;
    do_reset();

    // Table vectors
    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].idx, vecs[k].data, vecs[k].clr_req);
      step();
      chk("tbl_we", we_a, vecs[k].e_we);
      chk("tbl_addr", addr_a, vecs[k].e_addr);
      chk("tbl_data", data_a, vecs[k].e_data);
      chk("tbl_err", err_index, vecs[k].e_err);
      chk("tbl_count", write_count, vecs[k].e_cnt);
    end
    chk("tbl_busy_idle", busy, 1'b0);

    // Burst: indices 0..5 back to back give consecutive writes
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'(i), 16'(16'hB000 + i), 0);
      step();
      if (i > 0) begin
        chk("burst_we", we_a, 1'b1);
        chk("burst_addr", addr_a, BASE + 10'(i - 1));
      end
    end
    drive(0, 0, 0, 0);
    step();
    chk("burst_last", addr_a, 10'h105);
    step();

    // Clear with one request accepted in the same cycle
    c0 = write_count;
    drive(1, 5'd2, 16'h1234, 1);
    step();
    drive(1, 5'd9, 16'h9999, 0);
    step();
    chk("clr_first_addr", addr_a, 10'h102);
    chk("clr_first_data", data_a, 16'h1234);
    for (int i = 0; i < 31; i++) begin
      chk("clr_ready_low", req_ready, 1'b0);
      step();
    end
    chk("clr_count_delta", write_count - c0, 8'd31);
    chk("clr_last_addr", addr_a, 10'h11D);
    chk("clr_last_data", data_a, 16'h0000);
    drive(0, 0, 0, 0);
    step();
    chk("clr_done_we", we_a, 1'b0);

    // Reset in the middle of a clear
    c0 = write_count;
    drive(0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 20 && 8'(write_count - c0) < 8'd10; i++) step();
    chk("midclr_reached", write_count - c0, 8'd10);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midclr_no_write", we_a, 1'b0);
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 33)), 16'($urandom),
              $urandom_range(0, 99) < 3);
        step();
      end
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
